// File: rtl/imem_loader.sv
// imem_loader: packs a valid/ready byte stream into little-endian 32-bit IMem words and holds the CPU while loading.
// Optional IMEM_LOADER_CKSUM_EN adds a trailing checksum byte and the cksum_err output.
module imem_loader #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len_in,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold
`ifdef IMEM_LOADER_CKSUM_EN
  ,
  output logic              cksum_err
`endif
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

`ifdef IMEM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, CKSUM} state_t;
  localparam state_t AFTER_LAST = CKSUM;
`else
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  localparam state_t AFTER_LAST = DONE;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_word;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              err_q, err_d;
`endif

  // Word index is one bit wider than the address so a full-depth load never wraps to 0.
  assign last_word = (widx_q == len_q - ONE);
  assign busy      = (state_q != IDLE);
  assign cpu_hold  = busy;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
`ifdef IMEM_LOADER_CKSUM_EN
  assign cksum_err = err_q;
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    widx_d     = widx_q;
    bidx_d     = bidx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
    sum_d      = sum_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d  = (len_in > DEPTH) ? DEPTH : len_in;
          widx_d = '0;
          bidx_d = '0;
`ifdef IMEM_LOADER_CKSUM_EN
          sum_d  = '0;
          err_d  = 1'b0;
`endif
          state_d = (len_in == '0) ? AFTER_LAST : RECV;
        end
      end
      RECV: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          wdata_d[{bidx_q, 3'b000} +: 8] = byte_in;
          bidx_d = bidx_q + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
          sum_d  = sum_q + byte_in;
`endif
          if (bidx_q == 2'd3) begin
            addr_d  = widx_q[ADDR_W-1:0];
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        mem_we  = 1'b1;
        widx_d  = widx_q + ONE;
        bidx_d  = '0;
        state_d = last_word ? AFTER_LAST : RECV;
      end
`ifdef IMEM_LOADER_CKSUM_EN
      CKSUM: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          sum_d   = sum_q + byte_in;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        done    = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
        err_d   = (sum_q != 8'h00);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule
